// File: rtl/axi_stream_remove_header.sv
// Strips N leading bytes (N latched from a side command) from each AXI Stream packet and
// realigns the remaining bytes MSB-first onto full beats. Define AXIS_REMOVE_HEADER_STATS_EN for packet counters.
module axi_stream_remove_header #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    ready_in,
   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    ready_out,
   input  logic                    valid_remove,
   input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
   output logic                    ready_remove
`ifdef AXIS_REMOVE_HEADER_STATS_EN
   ,
   output logic [15:0]             pkt_out_cnt,
   output logic [15:0]             pkt_drop_cnt
`endif
);

   localparam int CW = BYTE_CNT_WD + 1;
   localparam logic [CW-1:0] W_C = CW'(DATA_BYTE_WD);

   typedef enum logic [1:0] {IDLE, FIRST, STREAM, FLUSH} state_t;

   // Valid/ready: a beat or command transfers on the rising edge where valid and ready are both
   // high; the output register only reloads when it is empty or being drained (out_free).
   state_t                  state, state_nxt;
   logic [BYTE_CNT_WD-1:0]  n_q;
   logic [DATA_WD-1:0]      res_q, res_nxt;
   logic [CW-1:0]           flush_cnt_q, flush_cnt_nxt;
   logic                    out_free, in_fire, cmd_fire;
   logic [CW-1:0]           beat_v, n_ext;
   logic [DATA_WD-1:0]      data_shl, data_top;
   logic                    load_out, last_nxt;
   logic [DATA_WD-1:0]      data_nxt;
   logic [DATA_BYTE_WD-1:0] keep_nxt;

   function automatic logic [CW-1:0] popcount(input logic [DATA_BYTE_WD-1:0] k);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CW'(k[i]);
      return c;
   endfunction

   function automatic logic [DATA_BYTE_WD-1:0] keep_mask(input logic [CW-1:0] cnt);
      logic [DATA_BYTE_WD-1:0] m;
      m = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) m[DATA_BYTE_WD-1-i] = (CW'(i) < cnt);
      return m;
   endfunction

   assign out_free     = !valid_out || ready_out;
   assign ready_in     = ((state == FIRST) || (state == STREAM)) && out_free;
   assign ready_remove = (state == IDLE);
   assign in_fire      = valid_in && ready_in;
   assign cmd_fire     = valid_remove && ready_remove;
   assign n_ext        = {1'b0, n_q};
   assign beat_v       = popcount(keep_in);
   // Residual is kept left-aligned; the top N bytes of the next beat fill its low N bytes.
   assign data_shl     = data_in << {n_q, 3'b000};
   assign data_top     = data_in >> {W_C - n_ext, 3'b000};

   always_comb begin
      state_nxt     = state;
      res_nxt       = res_q;
      flush_cnt_nxt = flush_cnt_q;
      load_out      = 1'b0;
      data_nxt      = '0;
      keep_nxt      = '0;
      last_nxt      = 1'b0;
      case (state)
         IDLE: if (cmd_fire) state_nxt = FIRST;
         FIRST: if (in_fire) begin
            if (!last_in) begin
               res_nxt   = data_shl;
               state_nxt = STREAM;
            end else begin
               state_nxt = IDLE;
               if (beat_v > n_ext) begin
                  load_out = 1'b1;
                  data_nxt = data_shl;
                  keep_nxt = keep_mask(beat_v - n_ext);
                  last_nxt = 1'b1;
               end
            end
         end
         STREAM: if (in_fire) begin
            load_out = 1'b1;
            data_nxt = res_q | data_top;
            keep_nxt = '1;
            res_nxt  = data_shl;
            if (last_in) begin
               if (beat_v <= n_ext) begin
                  keep_nxt  = keep_mask(W_C - n_ext + beat_v);
                  last_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  flush_cnt_nxt = beat_v - n_ext;
                  state_nxt     = FLUSH;
               end
            end
         end
         FLUSH: if (out_free) begin
            load_out  = 1'b1;
            data_nxt  = res_q;
            keep_nxt  = keep_mask(flush_cnt_q);
            last_nxt  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         n_q         <= '0;
         res_q       <= '0;
         flush_cnt_q <= '0;
      end else begin
         state       <= state_nxt;
         res_q       <= res_nxt;
         flush_cnt_q <= flush_cnt_nxt;
         if (cmd_fire) n_q <= byte_remove_cnt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         keep_out  <= '0;
         last_out  <= 1'b0;
      end else if (load_out) begin
         valid_out <= 1'b1;
         data_out  <= data_nxt;
         keep_out  <= keep_nxt;
         last_out  <= last_nxt;
      end else if (ready_out) begin
         valid_out <= 1'b0;
         last_out  <= 1'b0;
      end
   end

`ifdef AXIS_REMOVE_HEADER_STATS_EN
   logic drop_pkt;
   assign drop_pkt = (state == FIRST) && in_fire && last_in && (beat_v <= n_ext);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_out_cnt  <= '0;
         pkt_drop_cnt <= '0;
      end else begin
         if (valid_out && ready_out && last_out && (pkt_out_cnt != 16'hFFFF))
            pkt_out_cnt <= pkt_out_cnt + 16'd1;
         if (drop_pkt && (pkt_drop_cnt != 16'hFFFF))
            pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Directed and randomized-handshake bench for axi_stream_remove_header (W=4).
// Output beats are scored against an expected queue built from hand-computed vectors or a byte-level model.
module tb_axi_stream_remove_header;

   localparam int DATA_WD      = 32;
   localparam int DATA_BYTE_WD = 4;
   localparam int BYTE_CNT_WD  = 2;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    valid_in;
   logic [DATA_WD-1:0]      data_in;
   logic [DATA_BYTE_WD-1:0] keep_in;
   logic                    last_in;
   logic                    ready_in;
   logic                    valid_out;
   logic [DATA_WD-1:0]      data_out;
   logic [DATA_BYTE_WD-1:0] keep_out;
   logic                    last_out;
   logic                    ready_out;
   logic                    valid_remove;
   logic [BYTE_CNT_WD-1:0]  byte_remove_cnt;
   logic                    ready_remove;
`ifdef AXIS_REMOVE_HEADER_STATS_EN
   logic [15:0]             pkt_out_cnt;
   logic [15:0]             pkt_drop_cnt;
`endif

   axi_stream_remove_header #(.DATA_WD(DATA_WD)) dut (
      .clk             (clk),
      .rst             (rst),
      .valid_in        (valid_in),
      .data_in         (data_in),
      .keep_in         (keep_in),
      .last_in         (last_in),
      .ready_in        (ready_in),
      .valid_out       (valid_out),
      .data_out        (data_out),
      .keep_out        (keep_out),
      .last_out        (last_out),
      .ready_out       (ready_out),
      .valid_remove    (valid_remove),
      .byte_remove_cnt (byte_remove_cnt),
      .ready_remove    (ready_remove)
`ifdef AXIS_REMOVE_HEADER_STATS_EN
      ,
      .pkt_out_cnt     (pkt_out_cnt),
      .pkt_drop_cnt    (pkt_drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Entries are {data[31:0], keep[3:0], last}.
   logic [36:0]            beat_q[$];
   logic [36:0]            exp_q[$];
   logic [BYTE_CNT_WD-1:0] cmd_q[$];
   logic                   cmd_fire_r  = 1'b0;
   logic                   beat_fire_r = 1'b0;
   bit                     rnd_valid   = 1'b0;
   bit                     rnd_ready   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] byte_mask(input logic [3:0] k);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{k[i]}};
      return m;
   endfunction

   task automatic push_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      beat_q.push_back({d, k, l});
   endtask

   task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
      exp_q.push_back({d, k, l});
   endtask

   // One clock: retire last cycle's handshakes, drive, then score the output register.
   task automatic step();
      logic [36:0] e;
      @(negedge clk);
      if (cmd_fire_r) begin
         void'(cmd_q.pop_front());
         valid_remove = 1'b0;
      end
      if (beat_fire_r) begin
         void'(beat_q.pop_front());
         valid_in = 1'b0;
      end
      if (!valid_remove && cmd_q.size() > 0 && (!rnd_valid || $urandom_range(0, 1) == 1)) begin
         valid_remove    = 1'b1;
         byte_remove_cnt = cmd_q[0];
      end
      if (!valid_in && beat_q.size() > 0 && (!rnd_valid || $urandom_range(0, 1) == 1)) begin
         valid_in = 1'b1;
         {data_in, keep_in, last_in} = beat_q[0];
      end
      ready_out = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      cmd_fire_r  = valid_remove && ready_remove;
      beat_fire_r = valid_in && ready_in;
      if (valid_out) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", {31'd0, valid_out}, 32'd0);
         end else begin
            e = exp_q[0];
            chk("out_keep", {28'd0, keep_out}, {28'd0, e[4:1]});
            chk("out_last", {31'd0, last_out}, {31'd0, e[0]});
            chk("out_data", data_out & byte_mask(e[4:1]), e[36:5] & byte_mask(e[4:1]));
            if (ready_out) void'(exp_q.pop_front());
         end
      end
   endtask

   task automatic run(input int budget);
      int cyc;
      cyc = 0;
      do begin
         step();
         cyc++;
      end while ((cmd_q.size() > 0 || beat_q.size() > 0 || exp_q.size() > 0 ||
                  cmd_fire_r || beat_fire_r) && cyc < budget);
      chk("drain_pending", cmd_q.size() + beat_q.size() + exp_q.size(), 32'd0);
      cmd_q.delete();
      beat_q.delete();
      exp_q.delete();
      repeat (3) step();
   endtask

   // Random packet plus byte-level expectation: drop n leading bytes, repack left-aligned.
   task automatic gen_pkt();
      logic [7:0]  bq[$];
      logic [31:0] d;
      logic [3:0]  k;
      int n, nb, lv, v;
      n  = $urandom_range(0, 3);
      nb = $urandom_range(1, 4);
      lv = $urandom_range(1, 4);
      cmd_q.push_back(BYTE_CNT_WD'(n));
      for (int b = 0; b < nb; b++) begin
         v = (b == nb - 1) ? lv : 4;
         k = 4'hF;
         k = k << (4 - v);
         d = $urandom & byte_mask(k);
         push_beat(d, k, b == nb - 1);
         for (int j = 0; j < v; j++) bq.push_back(d[31-8*j -: 8]);
      end
      for (int j = 0; j < n; j++) if (bq.size() > 0) void'(bq.pop_front());
      while (bq.size() > 0) begin
         d = '0;
         k = '0;
         for (int j = 0; j < 4; j++) begin
            if (bq.size() > 0) begin
               d[31-8*j -: 8] = bq.pop_front();
               k[3-j] = 1'b1;
            end
         end
         push_exp(d, k, bq.size() == 0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
      valid_remove = 1'b0; byte_remove_cnt = '0; ready_out = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
      chk("rst_last_out", {31'd0, last_out}, 32'd0);
      chk("rst_data_out", data_out, 32'd0);
      chk("rst_keep_out", {28'd0, keep_out}, 32'd0);
      chk("rst_ready_in", {31'd0, ready_in}, 32'd0);
      chk("rst_ready_remove", {31'd0, ready_remove}, 32'd1);
      rst = 1'b0;

      // N=1, three-beat packet ending in a flush beat.
      cmd_q.push_back(2'd1);
      push_beat(32'hAABBCCDD, 4'hF, 1'b0);
      push_beat(32'h11223344, 4'hF, 1'b0);
      push_beat(32'h55660000, 4'hC, 1'b1);
      push_exp(32'hBBCCDD11, 4'hF, 1'b0);
      push_exp(32'h22334455, 4'hF, 1'b0);
      push_exp(32'h66000000, 4'h8, 1'b1);
      run(200);

      // N=3 single full beat, then N=3 single short beat that is consumed entirely.
      cmd_q.push_back(2'd3);
      push_beat(32'hAABBCCDD, 4'hF, 1'b1);
      push_exp(32'hDD000000, 4'h8, 1'b1);
      run(200);
      cmd_q.push_back(2'd3);
      push_beat(32'hAABB0000, 4'hC, 1'b1);
      run(200);
`ifdef AXIS_REMOVE_HEADER_STATS_EN
      chk("stat_out_cnt", {16'd0, pkt_out_cnt}, 32'd2);
      chk("stat_drop_cnt", {16'd0, pkt_drop_cnt}, 32'd1);
`endif

      // N=0: output lags one beat and ends with a flush beat.
      cmd_q.push_back(2'd0);
      push_beat(32'h01020304, 4'hF, 1'b0);
      push_beat(32'h05060000, 4'hC, 1'b1);
      push_exp(32'h01020304, 4'hF, 1'b0);
      push_exp(32'h05060000, 4'hC, 1'b1);
      run(200);

      // N=2, three beats under random downstream backpressure.
      rnd_ready = 1'b1;
      cmd_q.push_back(2'd2);
      push_beat(32'h10111213, 4'hF, 1'b0);
      push_beat(32'h14151617, 4'hF, 1'b0);
      push_beat(32'h18190000, 4'hC, 1'b1);
      push_exp(32'h12131415, 4'hF, 1'b0);
      push_exp(32'h16171819, 4'hF, 1'b1);
      run(400);
      rnd_ready = 1'b0;

      // Reset in STREAM with a stalled output beat.
      cmd_q.push_back(2'd1);
      push_beat(32'hAABBCCDD, 4'hF, 1'b0);
      push_beat(32'h11223344, 4'hF, 1'b0);
      push_exp(32'hBBCCDD11, 4'hF, 1'b0);
      run(200);
      @(negedge clk);
      valid_in = 1'b1; data_in = 32'h55667788; keep_in = 4'hF; last_in = 1'b0;
      ready_out = 1'b0;
      @(negedge clk);
      valid_in = 1'b0;
      chk("stall_valid_out", {31'd0, valid_out}, 32'd1);
      chk("stall_data_out", data_out, 32'h22334455);
      rst = 1'b1;
      #1;
      chk("midrst_valid_out", {31'd0, valid_out}, 32'd0);
      chk("midrst_keep_out", {28'd0, keep_out}, 32'd0);
      chk("midrst_ready_remove", {31'd0, ready_remove}, 32'd1);
      chk("midrst_ready_in", {31'd0, ready_in}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ready_out = 1'b1;
      #1;
      chk("postrst_ready_remove", {31'd0, ready_remove}, 32'd1);
      chk("postrst_valid_out", {31'd0, valid_out}, 32'd0);
      cmd_q.push_back(2'd2);
      push_beat(32'hAABBCCDD, 4'hF, 1'b1);
      push_exp(32'hCCDD0000, 4'hC, 1'b1);
      run(200);
`ifdef AXIS_REMOVE_HEADER_STATS_EN
      chk("stat_out_after_rst", {16'd0, pkt_out_cnt}, 32'd1);
      chk("stat_drop_after_rst", {16'd0, pkt_drop_cnt}, 32'd0);
`endif

      // 50 back-to-back packets with random valids and ready.
      rnd_valid = 1'b1;
      rnd_ready = 1'b1;
      for (int p = 0; p < 50; p++) gen_pkt();
      run(6000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_stream_remove_header.md
Name: axi_stream_remove_header

Overview:
Downstream companion to the header-insert stage. Strips a per-packet count of leading bytes (0..DATA_BYTE_WD-1) from an AXI Stream packet and realigns the remaining bytes onto full-width beats. The output is again MSB-first with a left-aligned keep on the last beat. It sits after the insert stage and consumes its output stream together with a side command giving the strip length.

Parameters:
DATA_WD, 32, data bus width in bits.
DATA_BYTE_WD, DATA_WD/8, bytes per beat (W).
BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of the strip count.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  asynchronous reset, active-high.
valid_in  in  1  input beat valid.
data_in  in  DATA_WD  input data; byte W-1 (top bits) is first in stream order.
keep_in  in  DATA_BYTE_WD  byte enables; 1111 on non-last beats, left-aligned (1111/1110/1100/1000) on the last beat.
last_in  in  1  last beat of packet.
ready_in  out  1  input beat accepted when valid_in&ready_in.
valid_out  out  1  output beat valid.
data_out  out  DATA_WD  realigned data.
keep_out  out  DATA_BYTE_WD  left-aligned byte enables.
last_out  out  1  last output beat.
ready_out  in  1  downstream ready.
valid_remove  in  1  strip command valid.
byte_remove_cnt  in  BYTE_CNT_WD  N = number of leading bytes to strip.
ready_remove  out  1  command accepted when valid_remove&ready_remove.

Behaviour:
- Reset (async, rst=1): state=IDLE; valid_out=0, last_out=0, data_out=0, keep_out=0; ready_in=0; ready_remove=1; residual buffer cleared.
- Output register: single entry, registered outputs; holds stable while valid_out&!ready_out. "out_free" = !valid_out | ready_out.
- IDLE: ready_remove=1, ready_in=0. On command handshake, latch N and go to FIRST.
- FIRST: ready_in=out_free. On accepted beat with V valid bytes (V = popcount of keep_in):
  - last_in=0: store the low W-N bytes as residual; no output; go to STREAM.
  - last_in=1, V>N: emit one beat = data_in shifted left by N bytes, keep = V-N bytes left-aligned, last_out=1; go to IDLE.
  - last_in=1, V<=N: packet fully consumed, nothing emitted; go to IDLE.
- STREAM: ready_in=out_free. Each accepted beat emits {residual (W-N bytes), top N bytes of data_in}; the residual is reloaded with the low W-N bytes.
  - On the last beat with V<=N: emitted beat has keep = (W-N)+V bytes, last_out=1; go to IDLE.
  - On the last beat with V>N: emitted beat has keep=1111, last_out=0; residual holds V-N bytes; go to FLUSH.
- FLUSH: ready_in=0. When out_free, emit residual left-aligned with keep = V-N bytes, last_out=1; go to IDLE.
- Latency: one beat from acceptance to valid_out. With N=0 the output lags by one extra beat and ends with a FLUSH beat.
- Data bytes outside keep_out are don't-care; the bench checks only kept bytes.
- Backpressure in any state freezes the state, the residual and the output register. No beat is lost or duplicated.
- A command presented while not in IDLE is not accepted (ready_remove=0). An input beat in IDLE is stalled.
- Reset mid-packet aborts immediately; the partial packet is discarded.

Optional Feature:
AXIS_REMOVE_HEADER_STATS_EN: when defined, adds two outputs.
- pkt_out_cnt [15:0]: increments on each output beat handshake with last_out=1.
- pkt_drop_cnt [15:0]: increments on a FIRST-state last beat with V<=N.
- Both saturate at 16'hFFFF and reset to 0.
When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
W=4, N=1, input beats AABBCCDD, 11223344, last 55660000 keep 1100 -> outputs BBCCDD11 keep 1111, 22334455 keep 1111, 66000000 keep 1000 last.
N=3, single beat AABBCCDD keep 1111 last -> one output DD000000 keep 1000 last. Same with keep 1100 -> no output; pkt_drop_cnt=1 (if enabled).
N=0, beats 01020304, 05060000 keep 1100 last -> 01020304 keep 1111, then 05060000 keep 1100 last (flush beat).
N=2, 3-beat packet with ready_out toggling randomly -> output sequence identical to ready_out=1 case; data_out stable while stalled.
rst asserted mid-packet in STREAM -> next cycle valid_out=0, ready_remove=1; a new packet then processes correctly.
Back-to-back commands and packets with valid_in/valid_remove random over 50 packets -> output byte stream equals the input stream with N bytes dropped per packet.
